// File: rtl/adder_bist_checker.sv
// adder_bist_checker
// Built-in self-test for a WIDTH-bit XOR/sum stage.
// It applies every A/B operand pair to the adder and waits SETTLE_CYCLES cycles.
// It then checks the returned sum_in against A ^ B.
// Mismatches are counted, saturating at the top of the ERR_W range.
// The first failing vector is latched for post-mortem inspection.
module adder_bist_checker #(
    parameter int WIDTH         = 1,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] sum_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_sum
);

    localparam int IDX_W = 2 * WIDTH;
    // The settle counter runs 0 .. SETTLE_CYCLES-1; keep it at least one bit wide
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CNT_LAST_I = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fail_valid_q, fail_valid_d;
    logic [WIDTH-1:0] fail_a_q, fail_a_d;
    logic [WIDTH-1:0] fail_b_q, fail_b_d;
    logic [WIDTH-1:0] fail_sum_q, fail_sum_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             mismatch;

    // Sum-stage comparison: pure XOR, no carry between bits
    assign mismatch = (sum_in != (a_q ^ b_q));

    // State register; reset aborts any sweep in the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                state_d = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = (idx_q == IDX_LAST) ? S_DONE : S_APPLY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: operand drive, settle timing, error capture, result flags
    always_comb begin
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_a_d     = fail_a_q;
        fail_b_d     = fail_b_q;
        fail_sum_d   = fail_sum_q;
        done_d       = done_q;
        pass_d       = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // A new sweep wipes results but leaves the last operands on the bus
                if (start) begin
                    idx_d        = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    fail_a_d     = '0;
                    fail_b_d     = '0;
                    fail_sum_d   = '0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                end
            end
            S_APPLY: begin
                a_d   = idx_q[IDX_W-1:WIDTH];
                b_d   = idx_q[WIDTH-1:0];
                cnt_d = '0;
            end
            S_SETTLE: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    // Only the first failing vector of a sweep is kept
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_a_d     = a_q;
                        fail_b_d     = b_q;
                        fail_sum_d   = sum_in;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    done_d = 1'b1;
                    pass_d = (err_q == '0) && !mismatch;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            fail_sum_q   <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_a_q     <= fail_a_d;
            fail_b_q     <= fail_b_d;
            fail_sum_q   <= fail_sum_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    // Output decode
    always_comb begin
        busy = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    end

    assign a_out      = a_q;
    assign b_out      = b_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_a     = fail_a_q;
    assign fail_b     = fail_b_q;
    assign fail_sum   = fail_sum_q;

endmodule

// File: tb/tb_adder_bist_checker.sv
// Directed bench for adder_bist_checker.
// u1 is WIDTH=1 with SETTLE_CYCLES=2, wrapped around a selectable adder model:
// correct XOR, output stuck at 0, or OR in place of XOR.
// u2 is WIDTH=2, ERR_W=2, SETTLE_CYCLES=0, wrapped around an inverted-XOR adder.
module tb_adder_bist_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start1;
    logic       start2;
    int         mode;

    logic [0:0] a1, b1, sum1, fa1, fb1, fs1;
    logic       busy1, done1, pass1, fv1;
    logic [7:0] err1;

    logic [1:0] a2, b2, sum2, fa2, fb2, fs2;
    logic       busy2, done2, pass2, fv2;
    logic [1:0] err2;

    int checks = 0;
    int errors = 0;
    int cyc;
    bit pass_early;

    // Adder models
    always_comb begin
        case (mode)
            0:       sum1 = a1 ^ b1;
            1:       sum1 = 1'b0;
            default: sum1 = a1 | b1;
        endcase
    end
    assign sum2 = ~(a2 ^ b2);

    adder_bist_checker #(.WIDTH(1), .SETTLE_CYCLES(2), .ERR_W(8)) u1 (
        .clk(clk), .rst(rst), .start(start1),
        .a_out(a1), .b_out(b1), .sum_in(sum1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1), .fail_sum(fs1)
    );

    adder_bist_checker #(.WIDTH(2), .SETTLE_CYCLES(0), .ERR_W(2)) u2 (
        .clk(clk), .rst(rst), .start(start2),
        .a_out(a2), .b_out(b2), .sum_in(sum2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_valid(fv2), .fail_a(fa2), .fail_b(fb2), .fail_sum(fs2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start on u1 and run until done (bounded). Entered at a negedge.
    // repulse_at >= 0 re-asserts start for one cycle at that point of the sweep.
    task automatic sweep1(input string tag, input int repulse_at, output int cycles, output bit early);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check({tag, "_done_drop"}, {30'd0, done1, pass1}, 32'd0);
        cycles = 0;
        early  = 1'b0;
        for (int n = 0; n < 400 && !done1; n++) begin
            if (busy1) cycles++;
            if (pass1) early = 1'b1;
            start1 = (n == repulse_at);
            @(negedge clk);
        end
        start1 = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        mode   = 0;
        repeat (3) @(negedge clk);

        // Reset state of both instances
        check("reset_u1", {20'd0, a1, b1, busy1, done1, pass1, err1, fv1, fa1, fb1, fs1}, 32'd0);
        check("reset_u2", {15'd0, a2, b2, busy2, done2, pass2, err2, fv2, fa2, fb2, fs2}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_start", {31'd0, busy1}, 32'd0);

        // Correct XOR adder
        mode = 0;
        sweep1("xor", -1, cyc, pass_early);
        $display("sweep xor: cycles=%0d done=%0d pass=%0d err=%0d", cyc, done1, pass1, err1);
        check("xor_cycles", cyc, 32'd16);
        check("xor_done_pass", {30'd0, done1, pass1}, 32'd3);
        check("xor_err", {24'd0, err1}, 32'd0);
        check("xor_fail_valid", {31'd0, fv1}, 32'd0);
        check("xor_pass_early", {31'd0, pass_early}, 32'd0);
        check("xor_last_vector", {30'd0, a1, b1}, 32'd3);
        repeat (3) @(negedge clk);
        check("done_held", {30'd0, done1, busy1}, 32'd2);

        // Output stuck at 0: vectors (0,1) and (1,0) fail
        mode = 1;
        sweep1("stuck0", -1, cyc, pass_early);
        $display("sweep stuck0: cycles=%0d err=%0d fail=%0d/%0d/%0d", cyc, err1, fa1, fb1, fs1);
        check("stuck0_cycles", cyc, 32'd16);
        check("stuck0_err", {24'd0, err1}, 32'd2);
        check("stuck0_done_pass", {30'd0, done1, pass1}, 32'd2);
        check("stuck0_fail", {28'd0, fv1, fa1, fb1, fs1}, 32'b1010);

        // OR in place of XOR: only (1,1) fails, observed 1
        mode = 2;
        sweep1("or", -1, cyc, pass_early);
        $display("sweep or: cycles=%0d err=%0d fail=%0d/%0d/%0d", cyc, err1, fa1, fb1, fs1);
        check("or_err", {24'd0, err1}, 32'd1);
        check("or_fail", {28'd0, fv1, fa1, fb1, fs1}, 32'b1111);
        check("or_pass", {31'd0, pass1}, 32'd0);

        // Reset during the SETTLE of the second vector
        mode = 1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy_vec", {29'd0, busy1, a1, b1}, 32'b101);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("mid-sweep reset: busy=%0d done=%0d a=%0d b=%0d", busy1, done1, a1, b1);
        check("mid_reset_clear", {20'd0, a1, b1, busy1, done1, pass1, err1, fv1, fa1, fb1, fs1}, 32'd0);
        @(negedge clk);
        check("mid_reset_idle", {30'd0, busy1, done1}, 32'd0);

        // Fresh sweep after the abort
        mode = 0;
        sweep1("fresh", -1, cyc, pass_early);
        $display("sweep fresh: cycles=%0d done=%0d pass=%0d", cyc, done1, pass1);
        check("fresh_cycles", cyc, 32'd16);
        check("fresh_done_pass", {30'd0, done1, pass1}, 32'd3);

        // Start re-pulsed while busy is ignored
        sweep1("repulse", 5, cyc, pass_early);
        $display("sweep repulse: cycles=%0d done=%0d pass=%0d", cyc, done1, pass1);
        check("repulse_cycles", cyc, 32'd16);
        check("repulse_done_pass", {30'd0, done1, pass1}, 32'd3);

        // Wide instance, zero settle, inverted sum: every vector fails
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 0;
        for (int n = 0; n < 400 && !done2; n++) begin
            if (busy2) cyc++;
            @(negedge clk);
        end
        $display("sweep wide: cycles=%0d err=%0d fail=%0d/%0d/%0d", cyc, err2, fa2, fb2, fs2);
        check("wide_cycles", cyc, 32'd32);
        check("wide_done_pass", {30'd0, done2, pass2}, 32'd2);
        check("wide_err_sat", {30'd0, err2}, 32'd3);
        check("wide_fail", {25'd0, fv2, fa2, fb2, fs2}, 32'b1000011);
        check("wide_last_vector", {28'd0, a2, b2}, 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
